// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit seven-segment display path.
// Segment codes are active-low, order gfedcba with bit0 = a.
package display_pkg;

  localparam int NUM_W       = 7;
  localparam int SHIFT_STEPS = 7;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE
  } state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Entry i is the pattern for digit i.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [3:0] add3(
    input logic [3:0] nib
  );
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/number_display_seg7.sv
// Combinational BCD nibble to active-low segment decoder.
// Non-decimal nibbles decode to blank.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (i_nib <= 4'd9)
      o_seg = SEG_TABLE[i_nib];
  end

endmodule

// File: rtl/number_display.sv
// Sequential double-dabble binary-to-BCD converter driving HEX1/HEX0.
// Display registers only update on the UPDATE state.
module number_display
  import display_pkg::*;
#(
  parameter bit BLANK_LEADING  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [6:0] number,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic       overflow,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1
);

  localparam logic [2:0] LAST_STEP = 3'(SHIFT_STEPS - 1);

  state_t           r_state;
  logic [NUM_W-1:0] r_bin;
  bcd_t             r_bcd;
  logic [2:0]       r_cnt;
  logic             r_ovf_cap;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;
  logic [6:0]       r_hex0;
  logic [6:0]       r_hex1;

  logic [7:0]       w_adj;
  logic [6:0]       w_seg_tens;
  logic [6:0]       w_seg_ones;
  logic [6:0]       w_hex1;
  logic [6:0]       w_hex0;

  function automatic logic [6:0] drive(
    input logic [6:0] seg
  );
    return SEG_ACTIVE_LOW ? seg : ~seg;
  endfunction

  assign w_adj = {add3(r_bcd.tens), add3(r_bcd.ones)};

  seg7_decode u_dec_tens (
    .i_nib (r_bcd.tens),
    .o_seg (w_seg_tens)
  );

  seg7_decode u_dec_ones (
    .i_nib (r_bcd.ones),
    .o_seg (w_seg_ones)
  );

  always_comb begin
    w_hex1 = w_seg_tens;
    w_hex0 = w_seg_ones;
    if (r_ovf_cap) begin
      w_hex1 = SEG_DASH;
      w_hex0 = SEG_DASH;
    end else if (BLANK_LEADING && r_bcd.tens == 4'd0) begin
      w_hex1 = SEG_BLANK;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_ovf_cap <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_hex0    <= drive(SEG_BLANK);
      r_hex1    <= drive(SEG_BLANK);
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load) begin
            r_bin     <= number;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_ovf_cap <= (number > 7'd99);
            r_busy    <= 1'b1;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd <= {w_adj[6:0], r_bin[NUM_W-1]};
          r_bin <= {r_bin[NUM_W-2:0], 1'b0};
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == LAST_STEP)
            r_state <= UPDATE;
        end
        UPDATE: begin
          r_hex1  <= drive(w_hex1);
          r_hex0  <= drive(w_hex0);
          r_ovf   <= r_ovf_cap;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_ovf;
  assign HEX0     = r_hex0;
  assign HEX1     = r_hex1;

endmodule

// File: doc/number_display.md
Name: number_display

Overview:
- Downstream consumer of the digit-to-value stage: takes its 7-bit `number` (0..99) and shows it as two decimal digits on the board's HEX1 (tens) and HEX0 (ones) seven-segment displays.
- Conversion is a sequential shift-add-3 (double-dabble), one bit per clock, behind a load/busy/done handshake.
- Outputs are registered and only change when a conversion completes, so the displays never show intermediate values.

Parameters:
- BLANK_LEADING, 1: when 1, a tens digit of 0 is blanked; when 0, it is shown as '0'.
- SEG_ACTIVE_LOW, 1: when 1, a segment is lit by driving 0 (DE-board HEX); when 0, segment outputs are inverted.

Ports:
- CLOCK_50  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- number  input  7  binary value to display; sampled only on an accepted load.
- load  input  1  request to convert `number`; accepted only in IDLE.
- busy  output  1  high while a conversion is in progress; load is ignored while high.
- done  output  1  one-cycle pulse when HEX0/HEX1/overflow have just been updated.
- overflow  output  1  registered; 1 if the last accepted number was greater than 99.
- HEX0  output  7  ones digit, segment order gfedcba, bit0 = a.
- HEX1  output  7  tens digit, same encoding.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; busy = 0, done = 0, overflow = 0.
  - HEX0 = HEX1 = blank (0x7F when active-low).
  - The shift register and counter are cleared.
  - Asserting reset mid-conversion aborts it; no done pulse follows.
- States: IDLE, SHIFT, UPDATE.
- IDLE:
  - If load = 1 at edge k: capture `number` into a 7-bit shift register and clear the 8-bit BCD accumulator (tens[7:4], ones[3:0]).
  - Also at edge k: set the iteration counter to 0, set busy = 1, go to SHIFT.
  - done is cleared on every IDLE edge that does not produce a new done.
- SHIFT, edges k+1..k+7:
  - Any BCD nibble that is at least 5 gets +3.
  - Then shift {bcd, bin} left by 1; the MSB of bin enters bcd[0].
  - The counter increments; after its 7th shift (counter = 6), go to UPDATE.
- UPDATE, edge k+8:
  - Register HEX1/HEX0 from the decoded nibbles, and register overflow.
  - Set done = 1 and busy = 0; go to IDLE.
- Latency: load at edge k gives new display values and done visible after edge k+8. busy is high for exactly 8 cycles.
- Overflow rule:
  - If the captured value is greater than 99, HEX1 = HEX0 = dash (segment g only, 0x3F active-low) and overflow = 1.
  - The BCD result is discarded. The shifter width is sized for 0..127, so it never wraps.
- Blanking: if BLANK_LEADING = 1, tens = 0 and no overflow, then HEX1 = blank. HEX0 always shows a digit, so 0 displays as a single '0'.
- load while busy is ignored (not queued), and busy stays high.
- load in the same cycle done is high (state IDLE) is accepted, so back-to-back conversions run every 9 cycles.
- `number` changing during SHIFT has no effect.
- Segment codes, active-low: 0 = 0x40, 1 = 0x79, 2 = 0x24, 3 = 0x30, 4 = 0x19, 5 = 0x12, 6 = 0x02, 7 = 0x78, 8 = 0x00, 9 = 0x10; blank = 0x7F; dash = 0x3F.
- Nibble values 10–15 cannot occur; the decoder maps them to blank.

Decomposition:
- Package display_pkg contains:
  - the state enum (IDLE, SHIFT, UPDATE);
  - SEG_BLANK and SEG_DASH;
  - the 10-entry digit-to-segment constant table;
  - NUM_W = 7 and SHIFT_STEPS = 7.
- Sub-module seg7_decode:
  - combinational, 4-bit nibble in, 7-bit segments out (active-low);
  - instantiated twice.
- Polarity inversion for SEG_ACTIVE_LOW = 0 is applied in the top level at the output registers.

Test Plan:
- Reset: hold reset = 0, then release. Required: HEX0 = HEX1 = 0x7F, busy = 0, done = 0, overflow = 0.
- number = 50, load pulse at edge k:
  - busy high for 8 cycles;
  - done pulses after edge k+8;
  - HEX1 = 0x12, HEX0 = 0x40.
- number = 7 with BLANK_LEADING = 1: HEX1 = 0x7F, HEX0 = 0x78. Repeat with BLANK_LEADING = 0: HEX1 = 0x40.
- number = 120: overflow = 1, HEX1 = HEX0 = 0x3F. Then number = 90: overflow = 0, HEX1 = 0x10, HEX0 = 0x40.
- Load 30, then re-pulse load with number = 80 at edge k+3:
  - the second load is ignored and the result is 30 (HEX1 = 0x30, HEX0 = 0x40);
  - a load of 80 on the done cycle is accepted and completes 9 cycles later with HEX1 = 0x00.
- Assert reset at edge k+4 of a conversion of 60: outputs go blank immediately, no done pulse, and a subsequent load of 60 completes normally.
